// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// mc_pkg : shared opcode/funct/aluOp/state constants for the multi-cycle control
// Rev 1.0
// ============================================================================
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FUNCT_SLL = 6'b000000;
   localparam logic [5:0] FUNCT_SRL = 6'b000010;

   localparam logic [3:0] ALUOP_ADD   = 4'b0000;
   localparam logic [3:0] ALUOP_SUB   = 4'b0001;
   localparam logic [3:0] ALUOP_RTYPE = 4'b0010;
   localparam logic [3:0] ALUOP_ADDI  = 4'b0011;
   localparam logic [3:0] ALUOP_ANDI  = 4'b0100;
   localparam logic [3:0] ALUOP_ORI   = 4'b0101;
   localparam logic [3:0] ALUOP_SLTI  = 4'b0110;
   localparam logic [3:0] ALUOP_XORI  = 4'b0111;
   localparam logic [3:0] ALUOP_SLL   = 4'b1000;
   localparam logic [3:0] ALUOP_SRL   = 4'b1001;
   localparam logic [3:0] ALUOP_ROTR  = 4'b1011;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMRD    = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWR    = 4'd5;
   localparam logic [3:0] S_RTYPE_EX = 4'd6;
   localparam logic [3:0] S_SHIFT_EX = 4'd7;
   localparam logic [3:0] S_ITYPE_EX = 4'd8;
   localparam logic [3:0] S_ALU_WB   = 4'd9;
   localparam logic [3:0] S_BEQ      = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;
   localparam logic [3:0] S_FAULT    = 4'd12;

   localparam logic [2:0] CLS_MEM     = 3'd0;
   localparam logic [2:0] CLS_RTYPE   = 3'd1;
   localparam logic [2:0] CLS_SHIFT   = 3'd2;
   localparam logic [2:0] CLS_BEQ     = 3'd3;
   localparam logic [2:0] CLS_JUMP    = 3'd4;
   localparam logic [2:0] CLS_ITYPE   = 3'd5;
   localparam logic [2:0] CLS_ILLEGAL = 3'd6;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Funct 000010 doubles as srl or rotr depending on IR[21].
   function automatic logic [3:0] shift_aluop(input logic [5:0] funct, input logic rotr);
      if (funct == FUNCT_SLL) return ALUOP_SLL;
      return rotr ? ALUOP_ROTR : ALUOP_SRL;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_opclass_decode.sv
`default_nettype none
// ============================================================================
// mc_opclass_decode : op/funct -> dispatch class and I-type aluOp (combinational)
// Rev 1.0
// ============================================================================
module mc_opclass_decode
   import mc_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   output logic [2:0] o_class,
   output logic [3:0] o_itype_alu_op
);

   always_comb begin
      o_class        = CLS_ILLEGAL;
      o_itype_alu_op = ALUOP_ADD;
      case (i_op)
         OP_LW, OP_SW: o_class = CLS_MEM;
         OP_RTYPE:     o_class = ((i_funct == FUNCT_SLL) || (i_funct == FUNCT_SRL)) ?
                                 CLS_SHIFT : CLS_RTYPE;
         OP_BEQ:       o_class = CLS_BEQ;
         OP_J:         o_class = CLS_JUMP;
         OP_ADDI: begin
            o_class        = CLS_ITYPE;
            o_itype_alu_op = ALUOP_ADDI;
         end
         OP_ANDI: begin
            o_class        = CLS_ITYPE;
            o_itype_alu_op = ALUOP_ANDI;
         end
         OP_ORI: begin
            o_class        = CLS_ITYPE;
            o_itype_alu_op = ALUOP_ORI;
         end
         OP_SLTI: begin
            o_class        = CLS_ITYPE;
            o_itype_alu_op = ALUOP_SLTI;
         end
         OP_XORI: begin
            o_class        = CLS_ITYPE;
            o_itype_alu_op = ALUOP_XORI;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control : main control FSM for the multi-cycle MIPS datapath
// Rev 1.0
// ============================================================================
module multicycle_control
   import mc_pkg::*;
#(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 5
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       halt_i,
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   input  logic       rotr_i,
   input  logic       mem_ack_i,
   output logic       memRead_o,
   output logic       memWrite_o,
   output logic       iorD_o,
   output logic       irWrite_o,
   output logic       pcWrite_o,
   output logic       pcWriteCond_o,
   output logic [1:0] pcSrc_o,
   output logic       aluSrcA_o,
   output logic [1:0] aluSrcB_o,
   output logic [3:0] aluOp_o,
   output logic       regDst_o,
   output logic       memToReg_o,
   output logic       regWrite_o,
   output logic       fault_o,
   output logic [3:0] state_o
);

   logic [3:0]       r_state;
   logic [3:0]       w_state_next;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0] w_wait_cnt_next;
   logic             r_reg_dst;
   logic             w_reg_dst_next;
   logic [2:0]       w_op_class;
   logic [3:0]       w_itype_alu_op;
   logic             w_req;
   logic             w_ack;
   logic             w_timeout;

   mc_opclass_decode u_decode (
      .i_op           (op_i),
      .i_funct        (funct_i),
      .o_class        (w_op_class),
      .o_itype_alu_op (w_itype_alu_op)
   );

   // A non-zero wait count in FETCH means a read is already outstanding, so halt is ignored.
   assign w_req = ((r_state == S_FETCH) && (!halt_i || (r_wait_cnt != '0))) ||
                  (r_state == S_MEMRD) || (r_state == S_MEMWR);
   assign w_ack     = w_req && mem_ack_i;
   assign w_timeout = w_req && !mem_ack_i && (r_wait_cnt == CNT_W'(WAIT_LIMIT - 1));

   assign w_wait_cnt_next = (w_req && !mem_ack_i && !w_timeout) ?
                            (r_wait_cnt + CNT_W'(1)) : '0;

   always_comb begin
      w_state_next   = r_state;
      w_reg_dst_next = r_reg_dst;
      if (w_timeout) begin
         w_state_next = S_FAULT;
      end else begin
         case (r_state)
            S_FETCH:  if (w_ack) w_state_next = S_DECODE;
            S_DECODE: begin
               case (w_op_class)
                  CLS_MEM:   w_state_next = S_MEMADR;
                  CLS_RTYPE: w_state_next = S_RTYPE_EX;
                  CLS_SHIFT: w_state_next = S_SHIFT_EX;
                  CLS_BEQ:   w_state_next = S_BEQ;
                  CLS_JUMP:  w_state_next = S_JUMP;
                  CLS_ITYPE: w_state_next = S_ITYPE_EX;
                  default:   w_state_next = S_FAULT;
               endcase
            end
            S_MEMADR: w_state_next = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (w_ack) w_state_next = S_MEMWB;
            S_MEMWR:  if (w_ack) w_state_next = S_FETCH;
            S_MEMWB:  w_state_next = S_FETCH;
            S_RTYPE_EX, S_SHIFT_EX: begin
               w_state_next   = S_ALU_WB;
               w_reg_dst_next = 1'b1;
            end
            S_ITYPE_EX: begin
               w_state_next   = S_ALU_WB;
               w_reg_dst_next = 1'b0;
            end
            S_ALU_WB, S_BEQ, S_JUMP: w_state_next = S_FETCH;
            S_FAULT:  w_state_next = S_FAULT;
            default:  w_state_next = S_FAULT;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state    <= S_FETCH;
         r_wait_cnt <= '0;
         r_reg_dst  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_cnt_next;
         r_reg_dst  <= w_reg_dst_next;
      end
   end

   assign state_o = r_state;

   // Outputs are forced to zero while reset is held, whatever state the register still holds.
   always_comb begin
      memRead_o     = 1'b0;
      memWrite_o    = 1'b0;
      iorD_o        = 1'b0;
      irWrite_o     = 1'b0;
      pcWrite_o     = 1'b0;
      pcWriteCond_o = 1'b0;
      pcSrc_o       = PCSRC_ALU;
      aluSrcA_o     = 1'b0;
      aluSrcB_o     = SRCB_REGB;
      aluOp_o       = ALUOP_ADD;
      regDst_o      = 1'b0;
      memToReg_o    = 1'b0;
      regWrite_o    = 1'b0;
      fault_o       = 1'b0;
      if (rst_ni) begin
         case (r_state)
            S_FETCH: begin
               aluSrcB_o = SRCB_FOUR;
               memRead_o = w_req;
               irWrite_o = w_ack;
               pcWrite_o = w_ack;
            end
            S_DECODE: aluSrcB_o = SRCB_IMMSH;
            S_MEMADR: begin
               aluSrcA_o = 1'b1;
               aluSrcB_o = SRCB_IMM;
            end
            S_MEMRD: begin
               memRead_o = 1'b1;
               iorD_o    = 1'b1;
            end
            S_MEMWB: begin
               regWrite_o = 1'b1;
               memToReg_o = 1'b1;
            end
            S_MEMWR: begin
               memWrite_o = 1'b1;
               iorD_o     = 1'b1;
            end
            S_RTYPE_EX: begin
               aluSrcA_o = 1'b1;
               aluOp_o   = ALUOP_RTYPE;
            end
            S_SHIFT_EX: begin
               aluSrcA_o = 1'b1;
               aluOp_o   = shift_aluop(funct_i, rotr_i);
            end
            S_ITYPE_EX: begin
               aluSrcA_o = 1'b1;
               aluSrcB_o = SRCB_IMM;
               aluOp_o   = w_itype_alu_op;
            end
            S_ALU_WB: begin
               regWrite_o = 1'b1;
               regDst_o   = r_reg_dst;
            end
            S_BEQ: begin
               aluSrcA_o     = 1'b1;
               aluOp_o       = ALUOP_SUB;
               pcWriteCond_o = 1'b1;
               pcSrc_o       = PCSRC_ALUOUT;
            end
            S_JUMP: begin
               pcWrite_o = 1'b1;
               pcSrc_o   = PCSRC_JUMP;
            end
            S_FAULT: fault_o = 1'b1;
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// tb_multicycle_control : directed + randomized instruction streams vs. phase model
// Rev 1.0
// ============================================================================
module tb_multicycle_control;

   localparam int WAIT_LIMIT = 4;
   localparam int CNT_W      = 3;

   localparam logic [5:0] T_RTYPE = 6'b000000;
   localparam logic [5:0] T_J     = 6'b000010;
   localparam logic [5:0] T_BEQ   = 6'b000100;
   localparam logic [5:0] T_LW    = 6'b100011;
   localparam logic [5:0] T_SW    = 6'b101011;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_op;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       fault;
   } ctl_t;

   typedef enum int {P_RESET, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWR, P_MEMWB,
                     P_EX, P_ALUWB, P_BEQ, P_JUMP, P_FAULT} phase_e;

   logic       clk_i = 1'b0;
   logic       rst_ni, halt_i, rotr_i, mem_ack_i;
   logic [5:0] op_i, funct_i;
   logic       memRead_o, memWrite_o, iorD_o, irWrite_o, pcWrite_o, pcWriteCond_o;
   logic       aluSrcA_o, regDst_o, memToReg_o, regWrite_o, fault_o;
   logic [1:0] pcSrc_o, aluSrcB_o;
   logic [3:0] aluOp_o, state_o;
   ctl_t       observed;

   int checks   = 0;
   int failures = 0;

   logic [3:0] itype_alu [logic [5:0]];
   logic [5:0] legal_ops [10];
   logic [5:0] illegal_ops [4];

   multicycle_control #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .halt_i        (halt_i),
      .op_i          (op_i),
      .funct_i       (funct_i),
      .rotr_i        (rotr_i),
      .mem_ack_i     (mem_ack_i),
      .memRead_o     (memRead_o),
      .memWrite_o    (memWrite_o),
      .iorD_o        (iorD_o),
      .irWrite_o     (irWrite_o),
      .pcWrite_o     (pcWrite_o),
      .pcWriteCond_o (pcWriteCond_o),
      .pcSrc_o       (pcSrc_o),
      .aluSrcA_o     (aluSrcA_o),
      .aluSrcB_o     (aluSrcB_o),
      .aluOp_o       (aluOp_o),
      .regDst_o      (regDst_o),
      .memToReg_o    (memToReg_o),
      .regWrite_o    (regWrite_o),
      .fault_o       (fault_o),
      .state_o       (state_o)
   );

   always #5 clk_i = ~clk_i;

   assign observed = {memRead_o, memWrite_o, iorD_o, irWrite_o, pcWrite_o, pcWriteCond_o,
                      pcSrc_o, aluSrcA_o, aluSrcB_o, aluOp_o, regDst_o, memToReg_o,
                      regWrite_o, fault_o};

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Control word the datapath should see for one cycle of a given instruction phase.
   function automatic ctl_t expected(phase_e ph, logic req, logic ack,
                                     logic [3:0] alu, logic [1:0] srcb, logic rd);
      ctl_t e;
      e = '0;
      case (ph)
         P_FETCH: begin
            e.alu_src_b = 2'b01;
            e.mem_read  = req;
            e.ir_write  = req && ack;
            e.pc_write  = req && ack;
         end
         P_DECODE: e.alu_src_b = 2'b11;
         P_MEMADR: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
         P_MEMRD:  begin e.mem_read = 1'b1; e.iord = 1'b1; end
         P_MEMWR:  begin e.mem_write = 1'b1; e.iord = 1'b1; end
         P_MEMWB:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
         P_EX:     begin e.alu_src_a = 1'b1; e.alu_src_b = srcb; e.alu_op = alu; end
         P_ALUWB:  begin e.reg_write = 1'b1; e.reg_dst = rd; end
         P_BEQ: begin
            e.alu_src_a = 1'b1; e.alu_op = 4'b0001;
            e.pc_write_cond = 1'b1; e.pc_src = 2'b01;
         end
         P_JUMP:   begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
         P_FAULT:  e.fault = 1'b1;
         default:  ;
      endcase
      return e;
   endfunction

   function automatic ctl_t simple(phase_e ph);
      return expected(ph, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);
   endfunction

   task automatic step(input string tag, input logic ack, input logic halt, input ctl_t exp_ctl);
      mem_ack_i = ack;
      halt_i    = halt;
      #1;
      checks++;
      assert (observed === exp_ctl) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, exp_ctl);
      end
      @(negedge clk_i);
   endtask

   // Request phase: `delay` cycles without ack, then the ack cycle; delay >= WAIT_LIMIT never acks.
   task automatic mem_access(input string tag, input phase_e ph, input int delay, output bit timed_out);
      int waits;
      waits     = (delay < WAIT_LIMIT) ? delay : WAIT_LIMIT;
      timed_out = (delay >= WAIT_LIMIT);
      for (int i = 0; i < waits; i++)
         step({tag, "_wait"}, 1'b0, (ph == P_FETCH && i == 0) ? 1'b0 : rbit(),
              expected(ph, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0));
      if (!timed_out)
         step({tag, "_ack"}, 1'b1, (ph == P_FETCH && delay == 0) ? 1'b0 : rbit(),
              expected(ph, 1'b1, 1'b1, 4'b0000, 2'b00, 1'b0));
   endtask

   task automatic fault_and_reset(input string tag);
      for (int i = 0; i < 3; i++)
         step({tag, "_fault"}, rbit(), rbit(), simple(P_FAULT));
      rst_ni = 1'b0;
      step({tag, "_rst"}, 1'b0, 1'b0, simple(P_RESET));
      rst_ni = 1'b1;
   endtask

   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] funct,
                            input logic rotr, input int halt_cycles, input int fetch_delay,
                            input int mem_delay);
      bit         to;
      logic [3:0] alu;
      op_i = op; funct_i = funct; rotr_i = rotr;
      for (int i = 0; i < halt_cycles; i++)
         step({tag, "_halt"}, 1'b0, 1'b1, expected(P_FETCH, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0));
      mem_access({tag, "_fetch"}, P_FETCH, fetch_delay, to);
      if (to) begin fault_and_reset(tag); return; end
      step({tag, "_decode"}, 1'b0, rbit(), simple(P_DECODE));
      if (op == T_LW || op == T_SW) begin
         step({tag, "_memadr"}, 1'b0, rbit(), simple(P_MEMADR));
         mem_access({tag, "_mem"}, (op == T_LW) ? P_MEMRD : P_MEMWR, mem_delay, to);
         if (to) begin fault_and_reset(tag); return; end
         if (op == T_LW) step({tag, "_memwb"}, 1'b0, rbit(), simple(P_MEMWB));
      end else if (op == T_RTYPE) begin
         if (funct == 6'b000000)      alu = 4'b1000;
         else if (funct == 6'b000010) alu = rotr ? 4'b1011 : 4'b1001;
         else                         alu = 4'b0010;
         step({tag, "_ex"}, 1'b0, rbit(), expected(P_EX, 1'b0, 1'b0, alu, 2'b00, 1'b0));
         step({tag, "_wb"}, 1'b0, rbit(), expected(P_ALUWB, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b1));
      end else if (op == T_BEQ) begin
         step({tag, "_beq"}, 1'b0, rbit(), simple(P_BEQ));
      end else if (op == T_J) begin
         step({tag, "_jump"}, 1'b0, rbit(), simple(P_JUMP));
      end else if (itype_alu.exists(op)) begin
         step({tag, "_ex"}, 1'b0, rbit(), expected(P_EX, 1'b0, 1'b0, itype_alu[op], 2'b10, 1'b0));
         step({tag, "_wb"}, 1'b0, rbit(), expected(P_ALUWB, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0));
      end else begin
         fault_and_reset(tag);
      end
   endtask

   initial begin
      int         pick, fd, md;
      logic [5:0] op, funct;

      itype_alu[6'b001000] = 4'b0011;
      itype_alu[6'b001100] = 4'b0100;
      itype_alu[6'b001101] = 4'b0101;
      itype_alu[6'b001010] = 4'b0110;
      itype_alu[6'b001110] = 4'b0111;
      legal_ops   = '{T_LW, T_SW, T_RTYPE, T_RTYPE, T_BEQ, T_J,
                      6'b001000, 6'b001100, 6'b001101, 6'b001010};
      illegal_ops = '{6'b111111, 6'b000001, 6'b100000, 6'b001111};

      rst_ni = 1'b0; halt_i = 1'b0; mem_ack_i = 1'b0;
      op_i = '0; funct_i = '0; rotr_i = 1'b0;
      @(negedge clk_i);
      step("reset0", 1'b0, 1'b0, simple(P_RESET));
      step("reset1", 1'b1, 1'b0, simple(P_RESET));
      rst_ni = 1'b1;

      run_instr("add",      T_RTYPE, 6'b100000, 1'b0, 0, 0, 0);
      run_instr("lw_slow",  T_LW,    6'b000000, 1'b0, 0, 3, 3);
      run_instr("srl",      T_RTYPE, 6'b000010, 1'b0, 0, 0, 0);
      run_instr("rotr",     T_RTYPE, 6'b000010, 1'b1, 0, 1, 0);
      run_instr("sll",      T_RTYPE, 6'b000000, 1'b1, 0, 0, 0);
      run_instr("beq",      T_BEQ,   6'b000000, 1'b0, 0, 0, 0);
      run_instr("j",        T_J,     6'b000000, 1'b0, 0, 2, 0);
      run_instr("sw",       T_SW,    6'b000000, 1'b0, 0, 1, 3);
      run_instr("xori",     6'b001110, 6'b000000, 1'b0, 0, 0, 0);
      run_instr("halt_ori", 6'b001101, 6'b000000, 1'b0, 2, 2, 0);
      run_instr("fetch_to", 6'b001000, 6'b000000, 1'b0, 0, WAIT_LIMIT, 0);
      run_instr("lw_to",    T_LW,    6'b000000, 1'b0, 0, 0, WAIT_LIMIT);
      run_instr("sw_to",    T_SW,    6'b000000, 1'b0, 0, 1, WAIT_LIMIT);
      run_instr("illegal",  6'b111111, 6'b000000, 1'b0, 0, 0, 0);

      // Reset pulse while a lw read is still waiting for its ack.
      op_i = T_LW;
      step("mid_fetch_ack", 1'b1, 1'b0, expected(P_FETCH, 1'b1, 1'b1, 4'b0000, 2'b00, 1'b0));
      step("mid_decode",    1'b0, 1'b0, simple(P_DECODE));
      step("mid_memadr",    1'b0, 1'b0, simple(P_MEMADR));
      step("mid_memrd",     1'b0, 1'b0, simple(P_MEMRD));
      rst_ni = 1'b0;
      step("mid_rst",       1'b0, 1'b0, simple(P_RESET));
      rst_ni = 1'b1;
      run_instr("after_rst", T_RTYPE, 6'b100010, 1'b0, 0, 0, 0);

      for (int n = 0; n < 80; n++) begin
         pick = $urandom_range(0, 10);
         op   = (pick == 10) ? illegal_ops[$urandom_range(0, 3)] : legal_ops[pick];
         case ($urandom_range(0, 2))
            0:       funct = 6'b000000;
            1:       funct = 6'b000010;
            default: funct = 6'($urandom_range(0, 63));
         endcase
         fd = ($urandom_range(0, 19) == 0) ? WAIT_LIMIT : $urandom_range(0, WAIT_LIMIT - 1);
         md = ($urandom_range(0, 9) == 0)  ? WAIT_LIMIT : $urandom_range(0, WAIT_LIMIT - 1);
         run_instr("rand", op, funct, rbit(), $urandom_range(0, 2), fd, md);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
